// File: rtl/main_memory.sv
// Fixed-latency byte-addressed memory model serving one outstanding request
// at a time from the cpu's unified instruction/data port. Reads and writes
// complete with a single-cycle pulse tagged as instruction or data.

package main_memory_pkg;
    typedef enum logic {
        SIZE_BYTE = 1'b0,
        SIZE_WORD = 1'b1
    } access_size_t;
endpackage

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; the first rd/wr seen here is latched
// BUSY  | latency countdown; all new requests are dropped
// RESP  | completion pulse on the outputs; a latched write commits here
module main_memory
    import main_memory_pkg::*;
#(
    parameter int    ADDR_WIDTH    = 32,
    parameter int    DATA_WIDTH    = 32,
    parameter int    MEM_SIZE      = 4096,
    parameter int    MEM_LATENCY   = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_req_valid_i,
    input  logic                  wr_req_valid_i,
    input  logic                  req_is_instr_i,
    input  logic [ADDR_WIDTH-1:0] req_address_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  access_size_t          req_access_size_i,
    output logic                  busy_o,
    output logic                  mem_data_valid_o,
    output logic                  mem_data_is_instr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(MEM_SIZE);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [IDX_W-1:0] ALIGN_MASK = ~IDX_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  accept;

    logic [IDX_W-1:0]      addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    access_size_t          size_q;
    logic                  instr_q;
    logic                  write_q;

    logic [IDX_W-1:0]      word_base;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [7:0]            mem [MEM_SIZE];

    // Address bits above the array index only wrap, they never select storage.
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^req_address_i[ADDR_WIDTH-1:IDX_W];

    // State and latency counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, one cycle of RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_req_valid_i || wr_req_valid_i) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture the request; a simultaneous write wins and is never an instruction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SIZE_BYTE;
            instr_q <= 1'b0;
            write_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_address_i[IDX_W-1:0];
            wdata_q <= wr_data_i;
            size_q  <= req_access_size_i;
            instr_q <= req_is_instr_i && !wr_req_valid_i;
            write_q <= wr_req_valid_i;
        end
    end

    assign word_base = addr_q & ALIGN_MASK;

    // Little-endian read of the latched address; bytes are zero-extended.
    always_comb begin
        rd_data = '0;
        if (size_q == SIZE_WORD) begin
            for (int b = 0; b < BYTES; b++) begin
                rd_data[8*b +: 8] = mem[word_base + IDX_W'(b)];
            end
        end else begin
            rd_data[7:0] = mem[addr_q];
        end
    end

    // Registered outputs; data and tag are forced to zero outside a read pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_o              <= 1'b0;
            mem_data_valid_o    <= 1'b0;
            mem_data_is_instr_o <= 1'b0;
            mem_data_o          <= '0;
        end else begin
            busy_o              <= (state_d != ST_IDLE);
            mem_data_valid_o    <= (state_d == ST_RESP);
            mem_data_is_instr_o <= (state_d == ST_RESP) && instr_q && !write_q;
            mem_data_o          <= (state_d == ST_RESP && !write_q) ? rd_data : '0;
        end
    end

    // Writes commit only on the edge leaving RESP, so a reset before then drops them.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_RESP && write_q) begin
            if (size_q == SIZE_WORD) begin
                for (int b = 0; b < BYTES; b++) begin
                    mem[word_base + IDX_W'(b)] <= wdata_q[8*b +: 8];
                end
            end else begin
                mem[addr_q] <= wdata_q[7:0];
            end
        end
    end

endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: a 5-cycle and a 1-cycle instance driven
// with random and directed traffic against a byte-array reference model.
module tb_main_memory;
    import main_memory_pkg::*;

    localparam int MS = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         rd_v   [2];
    logic         wr_v   [2];
    logic         instr  [2];
    logic [31:0]  addr   [2];
    logic [31:0]  wdat   [2];
    access_size_t asz    [2];
    logic         busy   [2];
    logic         vld    [2];
    logic         dinstr [2];
    logic [31:0]  dout   [2];

    main_memory #(.MEM_LATENCY(5)) dut0 (
        .clk_i(clk), .rst_i(rst_n),
        .rd_req_valid_i(rd_v[0]), .wr_req_valid_i(wr_v[0]), .req_is_instr_i(instr[0]),
        .req_address_i(addr[0]), .wr_data_i(wdat[0]), .req_access_size_i(asz[0]),
        .busy_o(busy[0]), .mem_data_valid_o(vld[0]), .mem_data_is_instr_o(dinstr[0]),
        .mem_data_o(dout[0])
    );

    main_memory #(.MEM_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n),
        .rd_req_valid_i(rd_v[1]), .wr_req_valid_i(wr_v[1]), .req_is_instr_i(instr[1]),
        .req_address_i(addr[1]), .wr_data_i(wdat[1]), .req_access_size_i(asz[1]),
        .busy_o(busy[1]), .mem_data_valid_o(vld[1]), .mem_data_is_instr_o(dinstr[1]),
        .mem_data_o(dout[1])
    );

    typedef struct {
        logic [31:0] data;
        logic        is_instr;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic [7:0] rm [2][MS];

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
        end
    endtask

    function automatic int qsize(input int k);
        if (k == 0) return q0.size();
        return q1.size();
    endfunction

    function automatic logic [31:0] ref_read(input int k, input logic [31:0] a, input access_size_t s);
        int i;
        i = int'(a % 32'd4096);
        if (s == SIZE_WORD) begin
            i = i - (i % 4);
            return {rm[k][i+3], rm[k][i+2], rm[k][i+1], rm[k][i]};
        end
        return {24'b0, rm[k][i]};
    endfunction

    function automatic void ref_write(input int k, input logic [31:0] a, input logic [31:0] d,
                                      input access_size_t s);
        int i;
        i = int'(a % 32'd4096);
        if (s == SIZE_WORD) begin
            i = i - (i % 4);
            for (int b = 0; b < 4; b++) rm[k][i+b] = d[8*b +: 8];
        end else begin
            rm[k][i] = d[7:0];
        end
    endfunction

    // Monitor: every pulse must match the oldest expectation; outside pulses outputs are 0.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (vld[k] === 1'b1) begin
                if (qsize(k) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse dut%0d @cyc %0d: got pulse data %h required no pulse",
                             k, cyc, dout[k]);
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("resp_data_dut%0d", k), dout[k], e.data);
                    chk($sformatf("resp_instr_dut%0d", k), {31'b0, dinstr[k]}, {31'b0, e.is_instr});
                    chk($sformatf("resp_cycle_dut%0d", k), 32'(cyc), 32'(e.due));
                end
            end else begin
                chk($sformatf("idle_outputs_dut%0d", k), dout[k] | {31'b0, dinstr[k]}, 32'd0);
            end
        end
    end

    // junk: 0 none, 1 random spurious requests while busy, 2 spurious request every busy cycle
    task automatic issue(input int k, input bit rd, input bit wr, input bit ins,
                         input logic [31:0] a, input logic [31:0] d, input access_size_t s,
                         input int junk, input bit chkb);
        int   n;
        int   t;
        int   lat;
        exp_t e;
        lat = (k == 0) ? 5 : 1;
        n = 0;
        while (busy[k] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL idle_wait_dut%0d: got busy %b required 0", k, busy[k]);
            return;
        end
        rd_v[k] = rd; wr_v[k] = wr; instr[k] = ins;
        addr[k] = a;  wdat[k] = d;  asz[k]   = s;
        @(posedge clk);
        #1;
        t = cyc;
        if (wr) begin
            ref_write(k, a, d, s);
            e.data = 32'd0;
            e.is_instr = 1'b0;
        end else begin
            e.data = ref_read(k, a, s);
            e.is_instr = ins;
        end
        e.due = t + lat;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        rd_v[k] = 1'b0;
        wr_v[k] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (chkb) chk($sformatf("busy_window_dut%0d", k), {31'b0, busy[k]},
                          (cyc <= t + lat) ? 32'd1 : 32'd0);
            if (busy[k] === 1'b1 && (junk == 2 || (junk == 1 && $urandom_range(0, 2) == 0))) begin
                rd_v[k]  = 1'b1;
                wr_v[k]  = 1'($urandom_range(0, 1));
                instr[k] = 1'($urandom_range(0, 1));
                addr[k]  = $urandom;
                wdat[k]  = $urandom;
                asz[k]   = access_size_t'($urandom_range(0, 1));
            end else begin
                rd_v[k] = 1'b0;
                wr_v[k] = 1'b0;
            end
        end while ((qsize(k) != 0 || cyc <= t + lat) && n < 100);
        rd_v[k] = 1'b0;
        wr_v[k] = 1'b0;
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout_dut%0d: got no pulse required pulse at cyc %0d", k, t + lat);
            if (k == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    task automatic rand_op(input int k, input logic [31:0] mask, input int junk);
        logic [31:0] a;
        int kind;
        a = $urandom & mask;
        kind = $urandom_range(0, 4);
        case (kind)
            0: issue(k, 1, 0, 1'($urandom_range(0, 1)), a, $urandom, SIZE_WORD, junk, 0);
            1: issue(k, 1, 0, 1'($urandom_range(0, 1)), a, $urandom, SIZE_BYTE, junk, 0);
            2: issue(k, 0, 1, 0, a, $urandom, SIZE_WORD, junk, 0);
            3: issue(k, 0, 1, 0, a, $urandom, SIZE_BYTE, junk, 0);
            default: issue(k, 1, 1, 1, a, $urandom, access_size_t'($urandom_range(0, 1)), junk, 0);
        endcase
    endtask

    initial begin
        #1_000_000;
        checks++;
        failures++;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd_v[k] = 1'b0; wr_v[k] = 1'b0; instr[k] = 1'b0;
            addr[k] = '0;   wdat[k] = '0;   asz[k]   = SIZE_WORD;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_busy", {31'b0, busy[k]}, 32'd0);
            chk("reset_valid", {31'b0, vld[k]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Known contents for every address the random traffic can reach.
        for (int i = 0; i < 256; i++) issue(0, 0, 1, 0, 32'(i * 4), $urandom, SIZE_WORD, 0, 0);
        for (int i = 0; i < 64; i++)  issue(1, 0, 1, 0, 32'(i * 4), $urandom, SIZE_WORD, 0, 0);

        // Instruction fetch with latency and busy-window checks.
        issue(0, 0, 1, 0, 32'h0, 32'h0000_0013, SIZE_WORD, 0, 0);
        issue(0, 1, 0, 1, 32'h0, 32'h0, SIZE_WORD, 0, 1);

        // Little-endian byte and unaligned-word reads.
        issue(0, 0, 1, 0, 32'h100, 32'hDEAD_BEEF, SIZE_WORD, 0, 0);
        issue(0, 1, 0, 0, 32'h101, 32'h0, SIZE_BYTE, 0, 0);
        issue(0, 1, 0, 0, 32'h102, 32'h0, SIZE_WORD, 0, 0);

        // Requests held through the whole busy window must be dropped.
        issue(0, 1, 0, 1, 32'h104, 32'h0, SIZE_WORD, 2, 1);
        issue(0, 0, 1, 0, 32'h108, 32'h1234_5678, SIZE_BYTE, 2, 0);

        // Wrap-around past the array end.
        issue(0, 0, 1, 0, 32'h1004, 32'h1122_3344, SIZE_WORD, 0, 0);
        issue(0, 1, 0, 0, 32'h0004, 32'h0, SIZE_WORD, 0, 0);

        // Reset two cycles into a store: no pulse, store discarded.
        rd_v[0] = 1'b0; wr_v[0] = 1'b1; instr[0] = 1'b0;
        addr[0] = 32'h20; wdat[0] = 32'hCAFE_F00D; asz[0] = SIZE_WORD;
        @(posedge clk);
        #1;
        wr_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'b0, busy[0]}, 32'd0);
        repeat (2) @(negedge clk);
        chk("midreset_valid", {31'b0, vld[0]}, 32'd0);
        rst_n = 1'b1;
        issue(0, 1, 0, 0, 32'h20, 32'h0, SIZE_WORD, 0, 0);

        // Randomized traffic with spurious requests while busy.
        for (int i = 0; i < 300; i++) rand_op(0, 32'hFFFF_F3FF, 1);

        // Single-cycle latency instance.
        issue(1, 0, 1, 0, 32'h40, 32'hA5A5_5A5A, SIZE_WORD, 0, 1);
        issue(1, 1, 0, 0, 32'h40, 32'h0, SIZE_WORD, 0, 1);
        issue(1, 1, 1, 1, 32'h80, 32'h0BAD_F00D, SIZE_WORD, 0, 0);
        issue(1, 1, 0, 1, 32'h80, 32'h0, SIZE_WORD, 0, 0);
        issue(1, 1, 0, 0, 32'h83, 32'h0, SIZE_BYTE, 0, 0);
        for (int i = 0; i < 150; i++) rand_op(1, 32'hFFFF_F0FF, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
